// File: rtl/kadai_pkg.sv
// Shared constants and helpers for the unsigned array multiplier.
// No logic, so no latency.
// No flow control.
package kadai_pkg;

  // Operand width used when the instantiating code does not override it
  localparam int DEFAULT_WIDTH = 2;

  // A full unsigned product of two w-bit operands always fits in 2*w bits
  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/kadai_09_6_2_full_adder.sv
// One-bit full adder cell for the multiplier adder array.
// Latency: purely combinational.
// No flow control.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/kadai_09_6_2.sv
// Unsigned WIDTH x WIDTH array multiplier with a combinational product and a registered copy.
// Latency: z is combinational; z_q/out_valid follow one cycle after an in_valid sample.
// No backpressure: every in_valid cycle is captured, and out_valid simply drops when in_valid is low.
module kadai_09_6_2
  import kadai_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
  input  logic                          in_valid,
  output logic [prod_width(WIDTH)-1:0]  z,
  output logic [prod_width(WIDTH)-1:0]  z_q,
  output logic                          out_valid
);

  // pp[i][j] is bit j of the multiplicand gated by bit i of the multiplier
  logic [WIDTH-1:0][WIDTH-1:0] pp;

  // row[i] holds the running sum after row i is added; bit 0 is final product bit i,
  // bits WIDTH:1 carry forward as the addend for the next row
  logic [WIDTH-1:0][WIDTH:0]   row;

  // Ripple carries inside each adder row (row 0 needs no adders)
  logic [WIDTH-1:1][WIDTH-1:0] carry;

  genvar i, j;

  // Partial-product AND plane
  for (i = 0; i < WIDTH; i++) begin : g_pp_row
    for (j = 0; j < WIDTH; j++) begin : g_pp_col
      assign pp[i][j] = a[j] & b[i];
    end
  end

  // The first row is just the unshifted partial products
  assign row[0] = {1'b0, pp[0]};

  // Each later row adds its partial products to the upper bits of the previous row
  for (i = 1; i < WIDTH; i++) begin : g_add_row
    for (j = 0; j < WIDTH; j++) begin : g_add_col
      if (j == 0) begin : g_ha
        full_adder u_fa (
          .x  (pp[i][j]),
          .y  (row[i-1][j+1]),
          .ci (1'b0),
          .s  (row[i][j]),
          .co (carry[i][j])
        );
      end else begin : g_fa
        full_adder u_fa (
          .x  (pp[i][j]),
          .y  (row[i-1][j+1]),
          .ci (carry[i][j-1]),
          .s  (row[i][j]),
          .co (carry[i][j])
        );
      end
    end
    assign row[i][WIDTH] = carry[i][WIDTH-1];
  end

  // Low product bits fall out of each row's LSB; the high half is the last row's upper bits
  for (i = 0; i < WIDTH; i++) begin : g_z_lo
    assign z[i] = row[i][0];
  end
  assign z[prod_width(WIDTH)-1:WIDTH] = row[WIDTH-1][WIDTH:1];

  // Capture the product on valid cycles; hold it otherwise, with out_valid as a one-cycle pulse per sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        z_q <= z;
      end
    end
  end

endmodule

// File: tb/tb_kadai_09_6_2.sv
module tb_kadai_09_6_2;

  logic       clk;
  logic       rst_n;
  logic [1:0] a;
  logic [1:0] b;
  logic       in_valid;
  logic [3:0] z;
  logic [3:0] z_q;
  logic       out_valid;

  logic [3:0] a4;
  logic [3:0] b4;
  logic       in_valid4;
  logic [7:0] z4;
  logic [7:0] z_q4;
  logic       out_valid4;

  int checks;
  int errors;

  kadai_09_6_2 #(.WIDTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .z         (z),
    .z_q       (z_q),
    .out_valid (out_valid)
  );

  kadai_09_6_2 #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a4),
    .b         (b4),
    .in_valid  (in_valid4),
    .z         (z4),
    .z_q       (z_q4),
    .out_valid (out_valid4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] z;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp4;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    a         = 2'd0;
    b         = 2'd0;
    in_valid  = 1'b0;
    a4        = 4'd0;
    b4        = 4'd0;
    in_valid4 = 1'b0;

    // Exhaustive sweep: b outer, a inner, expected products worked out by hand
    vecs[0]  = '{2'd0, 2'd0, 4'b0000};
    vecs[1]  = '{2'd1, 2'd0, 4'b0000};
    vecs[2]  = '{2'd2, 2'd0, 4'b0000};
    vecs[3]  = '{2'd3, 2'd0, 4'b0000};
    vecs[4]  = '{2'd0, 2'd1, 4'b0000};
    vecs[5]  = '{2'd1, 2'd1, 4'b0001};
    vecs[6]  = '{2'd2, 2'd1, 4'b0010};
    vecs[7]  = '{2'd3, 2'd1, 4'b0011};
    vecs[8]  = '{2'd0, 2'd2, 4'b0000};
    vecs[9]  = '{2'd1, 2'd2, 4'b0010};
    vecs[10] = '{2'd2, 2'd2, 4'b0100};
    vecs[11] = '{2'd3, 2'd2, 4'b0110};
    vecs[12] = '{2'd0, 2'd3, 4'b0000};
    vecs[13] = '{2'd1, 2'd3, 4'b0011};
    vecs[14] = '{2'd2, 2'd3, 4'b0110};
    vecs[15] = '{2'd3, 2'd3, 4'b1001};
    // Zero-operand corners
    vecs[16] = '{2'd0, 2'd3, 4'b0000};
    vecs[17] = '{2'd3, 2'd0, 4'b0000};

    // Reset state, and z is live even while reset is held
    #2;
    check("reset_z_q", 32'(z_q), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);

    for (int k = 0; k < 18; k++) begin
      a = vecs[k].a;
      b = vecs[k].b;
      #10;
      check($sformatf("comb_z[%0d]", k), 32'(z), 32'(vecs[k].z));
    end

    // Release reset away from a rising edge
    @(negedge clk);
    rst_n = 1'b1;

    // Single registered product
    a = 2'd3; b = 2'd3; in_valid = 1'b1;
    tick();
    check("reg_z_q", 32'(z_q), 32'h9);
    check("reg_out_valid", 32'(out_valid), 32'd1);

    // Drop valid: flag clears, data holds
    in_valid = 1'b0; a = 2'd1; b = 2'd1;
    tick();
    check("hold_out_valid", 32'(out_valid), 32'd0);
    check("hold_z_q", 32'(z_q), 32'h9);

    // Back-to-back valid samples
    a = 2'd2; b = 2'd1; in_valid = 1'b1;
    tick();
    check("b2b_0_z_q", 32'(z_q), 32'h2);
    check("b2b_0_vld", 32'(out_valid), 32'd1);
    a = 2'd1; b = 2'd3;
    tick();
    check("b2b_1_z_q", 32'(z_q), 32'h3);
    check("b2b_1_vld", 32'(out_valid), 32'd1);
    a = 2'd3; b = 2'd3;
    tick();
    check("b2b_2_z_q", 32'(z_q), 32'h9);
    check("b2b_2_vld", 32'(out_valid), 32'd1);

    // Asynchronous reset between edges with a sample in flight
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_z_q", 32'(z_q), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_z_live", 32'(z), 32'h9);
    a = 2'd2; b = 2'd3;
    #1;
    check("arst_z_tracks", 32'(z), 32'h6);
    tick();
    check("arst_held_z_q", 32'(z_q), 32'd0);
    check("arst_held_vld", 32'(out_valid), 32'd0);

    // First capture on the first rising edge after release
    @(negedge clk);
    rst_n = 1'b1;
    a = 2'd2; b = 2'd2;
    tick();
    check("post_rst_z_q", 32'(z_q), 32'h4);
    check("post_rst_vld", 32'(out_valid), 32'd1);
    in_valid = 1'b0;

    // WIDTH=4 instance
    a4 = 4'd15; b4 = 4'd15;
    #1;
    check("w4_max", 32'(z4), 32'hE1);
    for (int k = 0; k < 1000; k++) begin
      a4 = 4'($urandom_range(0, 15));
      b4 = 4'($urandom_range(0, 15));
      exp4 = int'(a4) * int'(b4);
      #1;
      check("w4_rand", 32'(z4), 32'(exp4));
    end
    check("w4_out_valid_idle", 32'(out_valid4), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kadai_09_6_2.md
# kadai_09_6_2

Unsigned array multiplier. Computes the full-width product of two WIDTH-bit operands (default 2×2 → 4 bits) combinationally on `z`, and also provides a registered copy `z_q` with a valid flag. It is a leaf arithmetic block used wherever a small, fixed-latency unsigned product is needed. The combinational path is the reference behaviour; the registered path lets downstream logic consume the product synchronously.

## Interface
- `WIDTH`, default 2: operand width in bits; must be ≥ 2.
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `a`: input, WIDTH bits. Unsigned multiplicand.
- `b`: input, WIDTH bits. Unsigned multiplier.
- `in_valid`: input, 1 bit. Qualifies `a`/`b` for the registered path.
- `z`: output, 2·WIDTH bits. Combinational product `a*b`.
- `z_q`: output, 2·WIDTH bits. Registered product.
- `out_valid`: output, 1 bit. `z_q` holds a product captured from a valid input.

## Operation
- `z` = `a` × `b`, unsigned, full 2·WIDTH-bit result.
  - No truncation or overflow is possible; the maximum product for WIDTH=2 is 3×3 = 9 = 4'b1001.
- The multiplier is built as an array:
  - Partial products `pp[i][j] = a[j] & b[i]`.
  - Rows are summed with ripple half/full adders.
  - No `*` operator in the datapath.
- `z` depends only on `a` and `b`. It is independent of `clk`, `rst_n` and `in_valid`.
- X/Z on any bit of `a` or `b` may propagate to `z`. No masking is required.
- Registered path, on the rising `clk` edge:
  - `in_valid`=1: `z_q` ← `z`, `out_valid` ← 1.
  - `in_valid`=0: `z_q` holds its value, `out_valid` ← 0.
- Reset (`rst_n`=0) clears `z_q` = 0 and `out_valid` = 0 immediately, without waiting for a clock edge.
- Reset has no effect on `z`.

## Timing
- `z`:
  - Zero-cycle latency; settles in the same simulation timestep as an operand change.
  - Must be stable within 1 ns of any input change in a unit-delay simulation.
- `z_q` / `out_valid`: latency of 1 cycle from an `in_valid`=1 sample.
  - Back-to-back valid inputs give one result per cycle.
- Reset:
  - Asserted mid-operation, it clears `z_q`/`out_valid` asynchronously; the in-flight sample is dropped.
  - Deassertion is synchronised by the user. The first capture occurs on the first rising edge with `rst_n`=1.
- Reset values: `z_q` = 0, `out_valid` = 0. `z` has no reset value; it always equals `a*b`.

## Structure
- Shared package `kadai_pkg`:
  - Default `WIDTH` constant.
  - Product-width function `2*WIDTH`.
- Sub-module `full_adder`:
  - Ports `x`, `y`, `ci` → `s`, `co`.
  - Instantiated in a generate grid to form the adder array.
  - Half adders are full adders with `ci` tied to 0.
- Top level contains:
  - the partial-product generate loop,
  - the adder array,
  - the output register with its asynchronous reset.

## Test plan
- Exhaustive combinational sweep, WIDTH=2:
  - Step `b` through 0..3 in the outer loop and `a` through 0..3 in the inner loop, 10 ns apart.
  - `z` = `a*b` at every step, e.g. a=01,b=01 → 0001; a=10,b=10 → 0100; a=11,b=10 → 0110; a=11,b=11 → 1001.
- Zero operand: a=00 with b=11, and a=11 with b=00 → `z`=0000.
- Registered path:
  - Apply a=11, b=11, `in_valid`=1 for one edge → next cycle `z_q`=1001, `out_valid`=1.
  - Drop `in_valid` → `out_valid`=0 and `z_q` holds 1001.
- Back-to-back: valid pairs (10,01), (01,11), (11,11) on consecutive edges → `z_q` = 0010, 0011, 1001 on the following edges.
- Asynchronous reset: with `z_q`=1001 and `out_valid`=1, pull `rst_n` low between clock edges.
  - `z_q`=0000 and `out_valid`=0 immediately.
  - `z` still tracks `a*b` throughout.
- Parameter check, WIDTH=4: a=15, b=15 → `z`=225 (8'hE1); random 1000 pairs match `a*b`.
